// File: rtl/alu_iter_exec.sv
// Execute-stage ALU. Logic, arithmetic and compare results are ready one cycle
// after accept; shifts move one bit position per cycle through a shared one-step shifter.
module alu_iter_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    // Shift kinds reuse the low two bits of the shift opcodes.
    localparam logic [1:0] KIND_SLL = 2'b01;
    localparam logic [1:0] KIND_SRA = 2'b11;

    typedef enum logic [1:0] {
        st_idle,
        st_shift,
        st_done
    } state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     shift_reg;
    logic [SHAMT_W-1:0]   count_reg;
    logic [1:0]           kind_reg;
    logic [WIDTH-1:0]     result_reg;
    logic                 zero_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic                 busy_reg;

    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic                 accept;
    logic [WIDTH-1:0]     alu_val;
    logic [WIDTH-1:0]     sum_val;
    logic [WIDTH-1:0]     diff_val;

    logic [WIDTH-1:0]     step_src;
    logic [1:0]           step_kind;
    logic                 step_left;
    logic                 step_arith;
    logic [WIDTH-1:0]     left_bits;
    logic [WIDTH-1:0]     right_bits;
    logic [WIDTH-1:0]     step_val;

    assign shamt    = src_b[SHAMT_W-1:0];
    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign accept   = in_valid && in_ready_reg;
    assign sum_val  = src_a + src_b;
    assign diff_val = src_a - src_b;

    always_comb begin
        alu_val = sum_val;
        case (alu_ctrl)
            OP_ADD:  alu_val = sum_val;
            OP_SUB:  alu_val = diff_val;
            OP_XOR:  alu_val = src_a ^ src_b;
            OP_OR:   alu_val = src_a | src_b;
            OP_AND:  alu_val = src_a & src_b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_val = src_a;
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default: alu_val = sum_val;
        endcase
    end

    // The first shift step happens in the accept cycle, so the source is the
    // live operand while idle and the shift register afterwards.
    assign step_src   = (state_reg == st_idle) ? src_a : shift_reg;
    assign step_kind  = (state_reg == st_idle) ? alu_ctrl[1:0] : kind_reg;
    assign step_left  = (step_kind == KIND_SLL);
    assign step_arith = (step_kind == KIND_SRA);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign left_bits[gi] = 1'b0;
            end else begin : g_lsh
                assign left_bits[gi] = step_src[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign right_bits[gi] = step_arith & step_src[WIDTH-1];
            end else begin : g_rsh
                assign right_bits[gi] = step_src[gi+1];
            end
        end
    endgenerate

    assign step_val = step_left ? left_bits : right_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= st_idle;
            shift_reg     <= '0;
            count_reg     <= '0;
            kind_reg      <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                st_idle: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        kind_reg     <= alu_ctrl[1:0];
                        if (!is_shift || (shamt == '0)) begin
                            result_reg    <= alu_val;
                            zero_reg      <= (alu_val == '0);
                            out_valid_reg <= 1'b1;
                            state_reg     <= st_done;
                        end else if (shamt == SHAMT_W'(1)) begin
                            result_reg    <= step_val;
                            zero_reg      <= (step_val == '0);
                            out_valid_reg <= 1'b1;
                            state_reg     <= st_done;
                        end else begin
                            shift_reg <= step_val;
                            count_reg <= shamt - SHAMT_W'(1);
                            state_reg <= st_shift;
                        end
                    end
                end
                st_shift: begin
                    if (count_reg == SHAMT_W'(1)) begin
                        result_reg    <= step_val;
                        zero_reg      <= (step_val == '0);
                        out_valid_reg <= 1'b1;
                        count_reg     <= '0;
                        state_reg     <= st_done;
                    end else begin
                        shift_reg <= step_val;
                        count_reg <= count_reg - SHAMT_W'(1);
                    end
                end
                st_done: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= st_idle;
                    end
                end
                default: begin
                    state_reg     <= st_idle;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;

endmodule
